// File: rtl/wm8731_i2c_slave.sv
// Write-only I2C responder standing in for the WM8731 control port: 3-byte frames update a 9-bit shadow file.
// Optional SCL/SDA debounce is compiled in with `define I2C_GLITCH_FILTER_EN.
module wm8731_i2c_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         FILTER_LEN = 4
) (
    input  logic       CLK_50M,
    input  logic       RSTn,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [3:0] RD_IDX,
    output logic [8:0] RD_DATA,
    output logic       WR_STB,
    output logic [6:0] WR_ADDR,
    output logic [8:0] WR_DATA,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE, DEVB, DEV_ACK, REGB, REG_ACK, DATB, DAT_ACK, IGNORE
    } state_t;

    localparam int NUM_REGS = 10;

    function automatic logic [8:0] shadow_default(input int idx);
        case (idx)
            0, 1:    shadow_default = 9'h097;
            2, 3:    shadow_default = 9'h079;
            4:       shadow_default = 9'h00A;
            5:       shadow_default = 9'h008;
            6:       shadow_default = 9'h09F;
            7:       shadow_default = 9'h00A;
            default: shadow_default = 9'h000;
        endcase
    endfunction

    // Bus lines idle high, so synchronisers and edge history reset to 1 to avoid a phantom START.
    logic [1:0] scl_sync_reg;
    logic [1:0] sda_sync_reg;
    logic [1:0] line_sync;
    logic [1:0] line_clean;
    logic [1:0] line_prev_reg;

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], SCL};
            sda_sync_reg <= {sda_sync_reg[0], SDA};
        end
    end

    assign line_sync = {sda_sync_reg[1], scl_sync_reg[1]};

    genvar gi;
`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic             level_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge CLK_50M or negedge RSTn) begin
                if (!RSTn) begin
                    level_reg <= 1'b1;
                    cnt_reg   <= '0;
                end else if (line_sync[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
                    level_reg <= line_sync[gi];
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign line_clean[gi] = level_reg;
        end
    endgenerate
`else
    assign line_clean = line_sync;
`endif

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) line_prev_reg <= 2'b11;
        else       line_prev_reg <= line_clean;
    end

    logic scl_cur, sda_cur, scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_evt, stop_evt;

    assign scl_cur   = line_clean[0];
    assign sda_cur   = line_clean[1];
    assign scl_prev  = line_prev_reg[0];
    assign sda_prev  = line_prev_reg[1];
    assign scl_rise  = !scl_prev && scl_cur;
    assign scl_fall  = scl_prev && !scl_cur;
    assign start_evt = scl_prev && scl_cur && sda_prev && !sda_cur;
    assign stop_evt  = scl_prev && scl_cur && !sda_prev && sda_cur;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] shift_reg, shift_next;
    logic [6:0] reg_idx_reg, reg_idx_next;
    logic       d8_reg, d8_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       commit;
    logic [7:0] byte_val;
    logic [8:0] commit_data;

    assign byte_val    = {shift_reg, sda_cur};
    assign commit_data = {d8_reg, byte_val};

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            reg_idx_reg <= '0;
            d8_reg      <= 1'b0;
            sda_oe_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            reg_idx_reg <= reg_idx_next;
            d8_reg      <= d8_next;
            sda_oe_reg  <= sda_oe_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        reg_idx_next = reg_idx_reg;
        d8_next      = d8_reg;
        sda_oe_next  = sda_oe_reg;
        busy_next    = busy_reg;
        commit       = 1'b0;

        if (stop_evt) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (start_evt) begin
            state_next   = DEVB;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b1;
        end else begin
            case (state_reg)
                DEVB, REGB, DATB: begin
                    if (scl_rise) begin
                        shift_next   = byte_val[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (state_reg == DEVB) begin
                                state_next = (byte_val[7:1] == DEV_ADDR && !byte_val[0]) ? DEV_ACK : IGNORE;
                            end else if (state_reg == REGB) begin
                                reg_idx_next = byte_val[7:1];
                                d8_next      = byte_val[0];
                                state_next   = REG_ACK;
                            end else begin
                                commit     = 1'b1;
                                state_next = DAT_ACK;
                            end
                        end
                    end
                end
                // First falling edge pulls SDA low for the ACK bit, the second one releases it.
                DEV_ACK, REG_ACK, DAT_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            if (state_reg == DEV_ACK) begin
                                state_next = REGB;
                            end else if (state_reg == REG_ACK) begin
                                state_next = DATB;
                            end else begin
                                state_next   = REGB;
                                reg_idx_next = reg_idx_reg + 7'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow register file; index 15 restores every register to its power-on value.
    logic [8:0] shadow_q    [NUM_REGS];
    logic [8:0] shadow_next [NUM_REGS];
    logic       restore;

    assign restore = commit && (reg_idx_reg == 7'd15);

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
            logic [8:0] value_reg;

            assign shadow_next[gi] = restore ? shadow_default(gi) :
                                     (commit && reg_idx_reg == 7'(gi)) ? commit_data : value_reg;

            always_ff @(posedge CLK_50M or negedge RSTn) begin
                if (!RSTn) value_reg <= shadow_default(gi);
                else       value_reg <= shadow_next[gi];
            end

            assign shadow_q[gi] = value_reg;
        end
    endgenerate

    logic [8:0] rd_data_reg;
    logic       wr_stb_reg;
    logic [6:0] wr_addr_reg;
    logic [8:0] wr_data_reg;

    // Reading the next-state view lets a same-cycle commit and read return the new value.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            rd_data_reg <= shadow_default(0);
            wr_stb_reg  <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            rd_data_reg <= (RD_IDX < 4'(NUM_REGS)) ? shadow_next[RD_IDX] : 9'h000;
            wr_stb_reg  <= commit;
            if (commit) begin
                wr_addr_reg <= reg_idx_reg;
                wr_data_reg <= commit_data;
            end
        end
    end

    assign SDA     = sda_oe_reg ? 1'b0 : 1'bz;
    assign RD_DATA = rd_data_reg;
    assign WR_STB  = wr_stb_reg;
    assign WR_ADDR = wr_addr_reg;
    assign WR_DATA = wr_data_reg;
    assign BUSY    = busy_reg;

endmodule
